// File: rtl/fq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fq_pkg;

  localparam int          FQ_XLEN     = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] ir;
  } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// DEPTH-entry circular buffer of {pc, ir} pairs; pointers wrap naturally since DEPTH is a power of two.
module fq_ring
  import fq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  fq_entry_t       wr_entry,
  output fq_entry_t       rd_entry,
  output logic [CW-1:0]   count
);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  fq_entry_t     mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; consumers gate it with the occupancy.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= wr_entry;
  end

  assign rd_entry = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC generator, in-order imem credit/drop tracking and a {pc, ir} queue to ID.
// Optional FQ_BYPASS_EN lets a response reach ID in its arrival cycle when the queue is empty.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter int               MAX_OUTS = 2,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_ir,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTS + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   inflight;
  logic [OW-1:0]   drop;
  logic [OW-1:0]   live;
  logic [CW-1:0]   count;
  logic            rsp_live;
  logic            push;
  logic            pop;
  logic            credit_ok;
  logic            outs_ok;
  fq_entry_t       rsp_entry;
  fq_entry_t       head_entry;
  fq_entry_t       head_sel;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  assign live      = inflight - drop;
  assign credit_ok = (32'(count) + 32'(live)) < DEPTH;
  assign outs_ok   = 32'(inflight) < MAX_OUTS;
  assign imem_req  = !rst && !redirect && credit_ok && outs_ok;
  assign imem_addr = fetch_pc;

  // A response in a redirect cycle belongs to the old path and is discarded.
  assign rsp_live  = imem_rvalid && (drop == '0) && !redirect;
  assign rsp_entry = '{pc: FQ_XLEN'(resp_pc), ir: FQ_XLEN'(imem_rdata)};

`ifdef FQ_BYPASS_EN
  logic bypass;
  assign bypass   = rsp_live && (count == '0);
  assign id_valid = (count != '0) || bypass;
  assign head_sel = (count != '0) ? head_entry : rsp_entry;
  assign push     = rsp_live && !(bypass && id_ready);
  assign pop      = (count != '0) && id_ready && !redirect;
`else
  assign id_valid = (count != '0);
  assign head_sel = head_entry;
  assign push     = rsp_live;
  assign pop      = id_valid && id_ready && !redirect;
`endif

  assign id_pc = id_valid ? XLEN'(head_sel.pc) : '0;
  assign id_ir = id_valid ? XLEN'(head_sel.ir) : '0;

  // PC, credit and squash bookkeeping, updated at the end of each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + OW'(imem_req) - OW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop     <= inflight - OW'(imem_rvalid);
      end else begin
        if (imem_req) fetch_pc <= pc_inc(fetch_pc);
        if (imem_rvalid) begin
          if (drop != '0) drop    <= drop - 1'b1;
          else            resp_pc <= pc_inc(resp_pc);
        end
      end
    end
  end

  fq_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (redirect),
    .wr_entry (rsp_entry),
    .rd_entry (head_entry),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: random imem latency, back-pressure and redirects against a program-order model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUTS = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic        id_ready;

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .MAX_OUTS (MAX_OUTS),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ir       (id_ir),
    .id_pc       (id_pc),
    .id_ready    (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    int          vis;
  } exp_t;

  mreq_t       mq[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          pops = 0;
  logic [31:0] next_pc = RESET_PC;
  int          lat_min = 1, lat_max = 1, p_ready = 100, p_redir = 0;
  bit          rst_req = 1'b1;
  bit          rst_prev = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: memory model, redirect, id_ready, then capture any request.
  task automatic step(input bit force_r = 1'b0, input logic [31:0] force_pc = 32'h0);
    mreq_t m;
    int    lat;
    int    due;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_req;
    if (rst) begin
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      id_ready    = 1'b0;
      mq.delete();
      exp_q.delete();
      epoch++;
      next_pc  = RESET_PC;
      last_due = cyc;
      rst_prev = 1'b1;
    end else begin
      redirect    = force_r || (!rst_prev && ($urandom_range(0, 99) < p_redir));
      redirect_pc = force_r ? force_pc : (32'($urandom_range(0, 1023)) << 2);
      rst_prev    = 1'b0;
      if (redirect) begin
        exp_q.delete();
        epoch++;
        next_pc = redirect_pc;
      end
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        m = mq.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m.addr);
        if (m.epoch == epoch) begin
          checks++;
          assert (exp_q.size() < DEPTH)
          else begin
            errors++;
            $display("FAIL overflow: live response with %0d queued, limit %0d", exp_q.size(), DEPTH);
          end
          exp_q.push_back('{pc: next_pc, ir: mem_word(next_pc), vis: cyc + 1});
          next_pc += 32'd4;
        end
      end
      id_ready = ($urandom_range(0, 99) < p_ready);
      #2;
      if (imem_req) begin
        lat = $urandom_range(lat_min, lat_max);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        mq.push_back('{addr: imem_addr, epoch: epoch, due: due});
      end
    end
  endtask

  // Monitor: compares the ID interface against the scoreboard head every cycle.
  bit          was_rst = 1'b0;
  bit          redir_prev = 1'b0;
  logic [31:0] redir_prev_pc = 32'h0;
  always @(negedge clk) begin
    bit vis;
    if (rst) begin
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_ir", id_ir, 32'd0);
      was_rst    = 1'b1;
      redir_prev = 1'b0;
    end else begin
      if (was_rst) begin
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
      end
      if (redir_prev) chk("addr_after_redirect", imem_addr, redir_prev_pc);
      if (redirect) begin
        chk("req_in_redirect", 32'(imem_req), 32'd0);
      end else begin
        vis = (exp_q.size() > 0) && (exp_q[0].vis <= cyc + BYP);
        chk("id_valid", 32'(id_valid), 32'(vis));
        if (vis) begin
          chk("id_pc", id_pc, exp_q[0].pc);
          chk("id_ir", id_ir, exp_q[0].ir);
        end else begin
          chk("id_pc_idle", id_pc, 32'd0);
          chk("id_ir_idle", id_ir, 32'd0);
        end
        if (vis && id_valid && id_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
      was_rst       = 1'b0;
      redir_prev    = redirect;
      redir_prev_pc = redirect_pc;
    end
  end

  task automatic do_reset();
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
  endtask

  initial begin
    int p0;
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Streaming with 1-cycle memory: one instruction per cycle.
    lat_min = 1; lat_max = 1; p_ready = 100; p_redir = 0;
    do_reset();
    repeat (10) step();
    p0 = pops;
    repeat (20) step();
    chk("throughput", 32'(pops - p0), 32'd20);

    // Back-pressure fills the queue and stalls fetch.
    do_reset();
    p_ready = 0;
    repeat (12) step();
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_count", 32'(exp_q.size()), 32'(DEPTH));
    chk("full_addr", imem_addr, RESET_PC + 32'h10);
    p_ready = 100;
    repeat (6) step();

    // Reset while the queue holds entries.
    p_ready = 0;
    repeat (4) step();
    do_reset();
    p_ready = 100;
    repeat (5) step();

    // Slow memory with redirects while requests are in flight, incl. wraparound target.
    lat_min = 3; lat_max = 3;
    repeat (3) step();
    step(1'b1, 32'h100);
    repeat (12) step();
    step(1'b1, 32'hFFFF_FFF8);
    repeat (10) step();

    // Back-to-back redirects: last one wins.
    lat_min = 1; lat_max = 4;
    repeat (3) step();
    step(1'b1, 32'h200);
    step(1'b1, 32'h300);
    repeat (10) step();

    // Random mixes.
    lat_min = 1; lat_max = 4; p_ready = 70; p_redir = 5;
    repeat (800) step();
    lat_min = 1; lat_max = 1; p_ready = 50; p_redir = 10;
    repeat (800) step();
    lat_min = 2; lat_max = 6; p_ready = 90; p_redir = 8;
    repeat (800) step();
    do_reset();
    p_redir = 0; p_ready = 100;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
